// File: rtl/priority_encoder_seq.sv
// rtl/priority_encoder_seq.sv - sequential priority encoder, one beat per set bit, high index first (option: PRIENC_MULTIHOT_ERR_EN)
module priority_encoder_seq #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_none,
  output logic         out_last,
  output logic         err_multi
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam logic [N-1:0] LSB_ONE = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         none_q, none_d;

  logic [W-1:0] top_idx;
  logic [N-1:0] top_mask;
  logic         single_hot;
  logic         last_beat;
  logic         accept;
  logic         beat_done;

  // Index of the highest set bit of the pending word; later iterations win
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) begin
        top_idx = W'(i);
      end
    end
  end

  assign top_mask   = LSB_ONE << top_idx;
  assign single_hot = (pending_q != '0) && ((pending_q & (pending_q - LSB_ONE)) == '0);
  // An all-zero word is a single beat, so it is always the last one
  assign last_beat  = none_q | single_hot;
  assign accept     = (state_q == ST_IDLE) && in_valid;
  assign beat_done  = (state_q == ST_EMIT) && out_ready;

  // State register and pending word, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end

  // Next state: load on acceptance, strip the emitted bit on each handshake
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = none_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_EMIT;
          pending_d = in_data;
          none_d    = (in_data == '0);
        end
      end
      ST_EMIT: begin
        if (beat_done) begin
          if (last_beat) begin
            state_d   = ST_IDLE;
            pending_d = '0;
            none_d    = 1'b0;
          end else begin
            pending_d = pending_q & ~top_mask;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = '0;
        none_d    = 1'b0;
      end
    endcase
  end

  // Outputs depend only on registered state, so they hold under backpressure
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_EMIT);
    out_idx   = out_valid ? top_idx : '0;
    out_none  = out_valid & none_q;
    out_last  = out_valid & last_beat;
  end

`ifdef PRIENC_MULTIHOT_ERR_EN
  logic err_q, err_d;
  logic in_multi;

  assign in_multi = (in_data & (in_data - LSB_ONE)) != '0;

  // Multi-hot flag captured with the word and cleared when it completes
  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = in_multi;
    end else if (beat_done && last_beat) begin
      err_d = 1'b0;
    end
  end

  // Multi-hot flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_multi = out_valid & err_q;
`else
  assign err_multi = 1'b0;
`endif

endmodule

// File: tb/tb_priority_encoder_seq.sv
// tb/tb_priority_encoder_seq.sv - directed self-checking bench for priority_encoder_seq
module tb_priority_encoder_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_idx;
  logic       out_none;
  logic       out_last;
  logic       err_multi;

  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] in_data4 = 4'h0;
  logic       out_valid4;
  logic       out_ready4 = 1'b1;
  logic [1:0] out_idx4;
  logic       out_none4;
  logic       out_last4;
  logic       err_multi4;

  int tests = 0;
  int fails = 0;

`ifdef PRIENC_MULTIHOT_ERR_EN
  localparam logic EXP_MULTI = 1'b1;
`else
  localparam logic EXP_MULTI = 1'b0;
`endif

  priority_encoder_seq #(.N(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_none(out_none), .out_last(out_last), .err_multi(err_multi)
  );

  priority_encoder_seq #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_idx(out_idx4),
    .out_none(out_none4), .out_last(out_last4), .err_multi(err_multi4)
  );

  always #5 clk = ~clk;

  // Present a word for one edge; returns on the negedge where the first beat is visible
  task automatic send_word(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    tests++; if (out_idx !== 3'd0) begin fails++; $display("FAIL reset_idx got=%0d exp=0", out_idx); end
    tests++; if (out_none !== 1'b0) begin fails++; $display("FAIL reset_none got=%b exp=0", out_none); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_last got=%b exp=0", out_last); end
    tests++; if (err_multi !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err_multi); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_post_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_single_hot_n4();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid4 = 1'b1;
      in_data4  = 4'b0001 << i;
      @(negedge clk);
      in_valid4 = 1'b0;
      tests++; if (out_valid4 !== 1'b1) begin fails++; $display("FAIL n4_valid[%0d] got=%b exp=1", i, out_valid4); end
      tests++; if (out_idx4 !== 2'(i)) begin fails++; $display("FAIL n4_idx[%0d] got=%0d exp=%0d", i, out_idx4, i); end
      tests++; if (out_last4 !== 1'b1) begin fails++; $display("FAIL n4_last[%0d] got=%b exp=1", i, out_last4); end
      tests++; if (out_none4 !== 1'b0) begin fails++; $display("FAIL n4_none[%0d] got=%b exp=0", i, out_none4); end
      @(negedge clk);
      tests++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin fails++; $display("FAIL n4_done[%0d] got valid=%b ready=%b exp valid=0 ready=1", i, out_valid4, in_ready4); end
    end
  endtask

  task automatic test_multi_bit();
    int exp_idx[4] = '{7, 5, 2, 0};
    out_ready = 1'b1;
    send_word(8'b1010_0101);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL multi_valid[%0d] got=%b exp=1", k, out_valid); end
      tests++; if (out_idx !== 3'(exp_idx[k])) begin fails++; $display("FAIL multi_idx[%0d] got=%0d exp=%0d", k, out_idx, exp_idx[k]); end
      tests++; if (out_last !== (k == 3)) begin fails++; $display("FAIL multi_last[%0d] got=%b exp=%b", k, out_last, (k == 3)); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL multi_ready[%0d] got=%b exp=0", k, in_ready); end
    end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL multi_done got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_zero_word();
    out_ready = 1'b1;
    send_word(8'h00);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL zero_valid got=%b exp=1", out_valid); end
    tests++; if (out_none !== 1'b1) begin fails++; $display("FAIL zero_none got=%b exp=1", out_none); end
    tests++; if (out_idx !== 3'd0) begin fails++; $display("FAIL zero_idx got=%0d exp=0", out_idx); end
    tests++; if (out_last !== 1'b1) begin fails++; $display("FAIL zero_last got=%b exp=1", out_last); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL zero_done got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_word(8'b1100_0000);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      tests++; if (out_valid !== 1'b1 || out_idx !== 3'd7) begin fails++; $display("FAIL bp_hold[%0d] got valid=%b idx=%0d exp valid=1 idx=7", c, out_valid, out_idx); end
      tests++; if (out_last !== 1'b0 || out_none !== 1'b0) begin fails++; $display("FAIL bp_flags[%0d] got last=%b none=%b exp 0 0", c, out_last, out_none); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out_idx !== 3'd6) begin fails++; $display("FAIL bp_second got valid=%b idx=%0d exp valid=1 idx=6", out_valid, out_idx); end
    tests++; if (out_last !== 1'b1) begin fails++; $display("FAIL bp_second_last got=%b exp=1", out_last); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_done got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_emit();
    out_ready = 1'b1;
    send_word(8'b1111_0000);
    tests++; if (out_idx !== 3'd7) begin fails++; $display("FAIL rstmid_first got=%0d exp=7", out_idx); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out_idx !== 3'd6) begin fails++; $display("FAIL rstmid_second got valid=%b idx=%0d exp valid=1 idx=6", out_valid, out_idx); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_async_valid got=%b exp=0", out_valid); end
    tests++; if (out_idx !== 3'd0 || out_last !== 1'b0) begin fails++; $display("FAIL rstmid_async_out got idx=%0d last=%b exp 0 0", out_idx, out_last); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_after[%0d] got valid=%b ready=%b exp valid=0 ready=1", c, out_valid, in_ready); end
    end
  endtask

  task automatic test_err_multi();
    out_ready = 1'b1;
    send_word(8'b0001_0001);
    tests++; if (out_idx !== 3'd4 || err_multi !== EXP_MULTI) begin fails++; $display("FAIL err_beat0 got idx=%0d err=%b exp idx=4 err=%b", out_idx, err_multi, EXP_MULTI); end
    @(negedge clk);
    tests++; if (out_idx !== 3'd0 || err_multi !== EXP_MULTI) begin fails++; $display("FAIL err_beat1 got idx=%0d err=%b exp idx=0 err=%b", out_idx, err_multi, EXP_MULTI); end
    tests++; if (out_last !== 1'b1) begin fails++; $display("FAIL err_beat1_last got=%b exp=1", out_last); end
    send_word(8'b0000_1000);
    tests++; if (out_idx !== 3'd3 || err_multi !== 1'b0) begin fails++; $display("FAIL err_single got idx=%0d err=%b exp idx=3 err=0", out_idx, err_multi); end
    tests++; if (out_last !== 1'b1) begin fails++; $display("FAIL err_single_last got=%b exp=1", out_last); end
    @(negedge clk);
    tests++; if (err_multi !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL err_idle got err=%b valid=%b exp 0 0", err_multi, out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'b0000_0011;
    @(negedge clk);
    tests++; if (out_idx !== 3'd1 || in_ready !== 1'b0) begin fails++; $display("FAIL b2b_first got idx=%0d ready=%b exp idx=1 ready=0", out_idx, in_ready); end
    in_data = 8'hFF;
    @(negedge clk);
    tests++; if (out_idx !== 3'd0 || out_last !== 1'b1) begin fails++; $display("FAIL b2b_second got idx=%0d last=%b exp idx=0 last=1", out_idx, out_last); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL b2b_gap got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (k < 7) @(negedge clk);
      tests++; if (out_valid !== 1'b1 || out_idx !== 3'(k)) begin fails++; $display("FAIL b2b_ff[%0d] got valid=%b idx=%0d exp valid=1 idx=%0d", k, out_valid, out_idx, k); end
      tests++; if (out_last !== (k == 0)) begin fails++; $display("FAIL b2b_ff_last[%0d] got=%b exp=%b", k, out_last, (k == 0)); end
    end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL b2b_done got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_single_hot_n4();
    test_multi_bit();
    test_zero_word();
    test_backpressure();
    test_reset_mid_emit();
    test_err_multi();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
